template_list_tx: RTL and testbench

//  Transmit end of the word/template-list byte protocol. Reads one word from an 8-bit

---
 rtl/template_list_tx.sv | 194 +++++++++++++++++++
 tb/tb_template_list_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/template_list_tx.sv
// Serialises one stored word, plus optional RANGE_INFO records, into the word/template-list
// byte stream. Optional TEMPLATE_LIST_TX_STATS_EN adds a saturating accepted-byte counter.
module template_list_tx #(
  parameter int WORD_MAX_LEN   = -1,
  parameter int RANGES_MAX     = -1,
  parameter int RANGE_INFO_MSB = (WORD_MAX_LEN < 2) ? 1 : $clog2(WORD_MAX_LEN),
  // Clamped copies keep widths legal if the mandatory parameters are left unset.
  localparam int Wml = (WORD_MAX_LEN < 2) ? 2 : WORD_MAX_LEN,
  localparam int Rm  = (RANGES_MAX < 1) ? 1 : RANGES_MAX,
  localparam int Aw  = $clog2(Wml),
  localparam int Fw  = RANGE_INFO_MSB + 1,
  localparam int Iw  = (Rm > 1) ? $clog2(Rm) : 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             is_template_list,
  input  logic             last_word,
  input  logic [Rm*Fw-1:0] range_info,
  output logic [Aw-1:0]    rd_addr,
  input  logic [7:0]       din,
  input  logic             empty,
  output logic             set_empty,
  output logic [7:0]       dout,
  output logic             wr_en,
  input  logic             full,
  output logic             pkt_end,
  output logic [15:0]      word_count,
`ifdef TEMPLATE_LIST_TX_STATS_EN
  output logic             err_word_count,
  output logic [31:0]      byte_count
`else
  output logic             err_word_count
`endif
);

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StRange, StDrain} state_e;

  state_e           state_q, state_d;
  logic [Aw-1:0]    rd_addr_q, rd_addr_d;
  logic [7:0]       dout_q, dout_d;
  logic             wr_en_q, wr_en_d;
  logic             pkt_end_q, pkt_end_d;
  logic             set_empty_q, set_empty_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             err_q, err_d;
  logic             tmpl_q, tmpl_d;
  logic             last_q, last_d;
  logic [Rm*Fw-1:0] ri_q, ri_d;
  logic [Iw-1:0]    idx_q, idx_d;

  logic          accept, can_load, word_end;
  logic [Fw-1:0] field;
  logic [7:0]    enc_byte;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    dout_d       = dout_q;
    wr_en_d      = wr_en_q;
    pkt_end_d    = pkt_end_q;
    set_empty_d  = 1'b0;
    word_count_d = word_count_q;
    err_d        = err_q;
    tmpl_d       = tmpl_q;
    last_d       = last_q;
    ri_d         = ri_q;
    idx_d        = idx_q;

    accept   = wr_en_q & ~full;
    can_load = ~wr_en_q | ~full;
    word_end = (din == 8'h00) || (rd_addr_q == Aw'(Wml - 1));
    field    = ri_q[int'(idx_q)*Fw +: Fw];

    // Range record byte: field MSB goes to bit 7, low field bits stay at the bottom.
    enc_byte    = '0;
    enc_byte[7] = field[RANGE_INFO_MSB];
    for (int k = 0; k < RANGE_INFO_MSB; k++) enc_byte[k] = field[k];

    if (accept) begin
      wr_en_d   = 1'b0;
      pkt_end_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // set_empty_q high means storage has not yet seen the release; empty is stale.
        if (!empty && !set_empty_q) begin
          tmpl_d    = is_template_list;
          last_d    = last_word;
          ri_d      = range_info;
          rd_addr_d = '0;
          state_d   = StRead;
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        if (can_load) begin
          dout_d  = din;
          wr_en_d = 1'b1;
          if (!word_end) begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = StRead;
          end else if (tmpl_q) begin
            idx_d   = '0;
            state_d = StRange;
          end else begin
            pkt_end_d = last_q;
            state_d   = StDrain;
          end
        end
      end
      StRange: begin
        if (can_load) begin
          dout_d  = enc_byte;
          wr_en_d = 1'b1;
          if (field == '0 || idx_q == Iw'(Rm - 1)) begin
            pkt_end_d = last_q;
            state_d   = StDrain;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (accept) begin
          set_empty_d = 1'b1;
          if (last_q) begin
            word_count_d = '0;
          end else begin
            word_count_d = word_count_q + 16'd1;
            if (word_count_q == 16'hFFFF) err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      dout_q       <= '0;
      wr_en_q      <= 1'b0;
      pkt_end_q    <= 1'b0;
      set_empty_q  <= 1'b0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      tmpl_q       <= 1'b0;
      last_q       <= 1'b0;
      ri_q         <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      dout_q       <= dout_d;
      wr_en_q      <= wr_en_d;
      pkt_end_q    <= pkt_end_d;
      set_empty_q  <= set_empty_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      tmpl_q       <= tmpl_d;
      last_q       <= last_d;
      ri_q         <= ri_d;
      idx_q        <= idx_d;
    end
  end

  assign rd_addr        = rd_addr_q;
  assign dout           = dout_q;
  assign wr_en          = wr_en_q;
  assign pkt_end        = pkt_end_q;
  assign set_empty      = set_empty_q;
  assign word_count     = word_count_q;
  assign err_word_count = err_q;

`ifdef TEMPLATE_LIST_TX_STATS_EN
  logic [31:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    if (accept && byte_count_q != 32'hFFFF_FFFF) byte_count_d = byte_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (rst) byte_count_q <= '0;
    else     byte_count_q <= byte_count_d;
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_template_list_tx.sv
// Scoreboard bench for template_list_tx: storage model feeds words, expected bytes are queued
// at load time and popped as the DUT hands bytes downstream.
module tb_template_list_tx;
  localparam int Wml = 8;
  localparam int Rm  = 4;
  localparam int Msb = 3;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        is_template_list = 1'b0;
  logic        last_word = 1'b0;
  logic [15:0] range_info = '0;
  logic [2:0]  rd_addr;
  logic [7:0]  din = '0;
  logic        empty = 1'b1;
  logic        set_empty;
  logic [7:0]  dout;
  logic        wr_en;
  logic        full = 1'b0;
  logic        pkt_end;
  logic [15:0] word_count;
  logic        err_word_count;
`ifdef TEMPLATE_LIST_TX_STATS_EN
  logic [31:0] byte_count;
`endif

  template_list_tx #(
    .WORD_MAX_LEN  (Wml),
    .RANGES_MAX    (Rm),
    .RANGE_INFO_MSB(Msb)
  ) dut (
    .CLK             (CLK),
    .rst             (rst),
    .is_template_list(is_template_list),
    .last_word       (last_word),
    .range_info      (range_info),
    .rd_addr         (rd_addr),
    .din             (din),
    .empty           (empty),
    .set_empty       (set_empty),
    .dout            (dout),
    .wr_en           (wr_en),
    .full            (full),
    .pkt_end         (pkt_end),
    .word_count      (word_count),
`ifdef TEMPLATE_LIST_TX_STATS_EN
    .byte_count      (byte_count),
`endif
    .err_word_count  (err_word_count)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  mem [Wml];
  logic [8:0]  exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          se_cnt = 0;
  int          se_before = 0;
  int          n_bytes = 0;
  int          full_mode = 0;
  logic [15:0] wc_exp = '0;
  logic        cur_last = 1'b0;

  // Synchronous-read storage model.
  always @(posedge CLK) din <= mem[rd_addr];

  // Backpressure driver: 0 = off, 1 = random, 2 = held high.
  always @(posedge CLK) begin
    #1;
    if (full_mode == 2)      full = 1'b1;
    else if (full_mode == 1) full = ($urandom_range(0, 2) == 0);
    else                     full = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!rst) begin
      if (set_empty) se_cnt++;
      if (wr_en && !full) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check_eq("dout", {24'd0, dout}, {24'd0, e[7:0]});
          check_eq("pkt_end", {31'd0, pkt_end}, {31'd0, e[8]});
        end
      end
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] f);
    return {f[3], 4'b0000, f[2:0]};
  endfunction

  task automatic push_expected(input logic [63:0] w, input logic t, input logic l,
                               input logic [15:0] ri);
    logic [7:0] bq [$];
    for (int i = 0; i < Wml; i++) begin
      bq.push_back(w[i*8 +: 8]);
      if (w[i*8 +: 8] == 8'h00) break;
    end
    if (t) begin
      for (int j = 0; j < Rm; j++) begin
        bq.push_back(enc(ri[j*4 +: 4]));
        if (ri[j*4 +: 4] == 4'h0) break;
      end
    end
    for (int i = 0; i < bq.size(); i++) exp_q.push_back({(l && i == bq.size() - 1), bq[i]});
  endtask

  task automatic load_word(input logic [63:0] w, input logic t, input logic l,
                           input logic [15:0] ri);
    for (int i = 0; i < Wml; i++) mem[i] = w[i*8 +: 8];
    is_template_list = t;
    last_word        = l;
    range_info       = ri;
    cur_last         = l;
    se_before        = se_cnt;
    push_expected(w, t, l, ri);
    empty = 1'b0;
  endtask

  task automatic finish_word();
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (set_empty) break;
    end
    check_eq("set_empty_seen", {31'd0, set_empty}, 32'd1);
    empty  = 1'b1;
    wc_exp = cur_last ? 16'd0 : wc_exp + 16'd1;
    check_eq("word_count", {16'd0, word_count}, {16'd0, wc_exp});
    repeat (3) @(negedge CLK);
    check_eq("set_empty_once", 32'(se_cnt), 32'(se_before + 1));
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check_eq({tag, "_dout"}, {24'd0, dout}, 32'd0);
    check_eq({tag, "_pkt_end"}, {31'd0, pkt_end}, 32'd0);
    check_eq({tag, "_set_empty"}, {31'd0, set_empty}, 32'd0);
    check_eq({tag, "_rd_addr"}, {29'd0, rd_addr}, 32'd0);
    check_eq({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err_word_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] hold_d;
    for (int i = 0; i < Wml; i++) mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    rst = 1'b0;

    // "ab\0", word list, last word
    load_word(64'h7A7A_7A7A_7A00_6261, 1'b0, 1'b1, 16'h0000);
    finish_word();
    // full-length word, no terminator
    load_word(64'h6867_6665_6463_6261, 1'b0, 1'b1, 16'h0000);
    finish_word();
    // template, range list ends on a zero field
    load_word(64'h7A7A_7A7A_7A7A_0061, 1'b1, 1'b0, 16'h0093);
    finish_word();
    // template, all fields nonzero
    load_word(64'h7A7A_7A7A_7A7A_0061, 1'b1, 1'b1, 16'h5A71);
    finish_word();
    // zero-length word
    load_word(64'h7A7A_7A7A_7A7A_7A00, 1'b0, 1'b0, 16'h0000);
    finish_word();

    // Backpressure held mid-word
    fork
      begin
        load_word(64'h6867_6665_6463_6261, 1'b0, 1'b0, 16'h0000);
        finish_word();
      end
      begin
        repeat (6) @(negedge CLK);
        full_mode = 2;
        repeat (3) @(negedge CLK);
        hold_d = dout;
        check_eq("hold_wr_en", {31'd0, wr_en}, 32'd1);
        repeat (5) begin
          @(negedge CLK);
          check_eq("hold_dout", {24'd0, dout}, {24'd0, hold_d});
          check_eq("hold_wr_en", {31'd0, wr_en}, 32'd1);
        end
        full_mode = 0;
      end
    join

    // Reset while emitting range records
    load_word(64'h7A7A_7A7A_7A7A_0061, 1'b1, 1'b0, 16'h5A71);
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (wr_en && !full && dout == 8'h00) break;
    end
    check_eq("range_reached", {24'd0, dout}, 32'd0);
    #1 rst = 1'b1;
    @(negedge CLK);
    check_idle_outputs("midrst");
    check_eq("midrst_no_release", 32'(se_cnt), 32'(se_before));
    exp_q.delete();
    wc_exp = '0;
    #1 rst = 1'b0;
    se_before = se_cnt;
    push_expected(64'h7A7A_7A7A_7A7A_0061, 1'b1, 1'b0, 16'h5A71);
    finish_word();

    // Random words under random backpressure
    full_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [63:0] w;
      int len;
      len = $urandom_range(0, Wml);
      for (int i = 0; i < Wml; i++) begin
        if (i < len)       w[i*8 +: 8] = 8'($urandom_range(1, 255));
        else if (i == len) w[i*8 +: 8] = 8'h00;
        else               w[i*8 +: 8] = 8'h7A;
      end
      load_word(w, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 16'($urandom));
      finish_word();
    end
    full_mode = 0;
    repeat (2) @(negedge CLK);
    check_eq("err_word_count", {31'd0, err_word_count}, 32'd0);
`ifdef TEMPLATE_LIST_TX_STATS_EN
    check_eq("byte_count_nonzero", 32'(byte_count != 0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
